// File: rtl/mem_inc.sv
// Shared memory-access types: access descriptor, arbiter state/owner and request payload.
package mem_inc;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef logic [XLEN-1:0] arch_reg_t;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_access_t access_size;
        mem_op_t     op;
        logic        load_unsigned;
    } mem_params_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_t;

    // Registered request held for the duration of one memory transaction
    typedef struct packed {
        arch_reg_t   addr;
        arch_reg_t   wdata;
        mem_params_t params;
        arb_owner_t  owner;
    } arb_req_t;

    localparam mem_params_t FETCH_PARAMS = '{
        access_size:   MEM_ACCESS_WORD,
        op:            MEM_OP_READ,
        load_unsigned: 1'b1
    };

    // Descriptor presented to memory whenever no transaction is in flight
    localparam mem_params_t IDLE_PARAMS = '{
        access_size:   MEM_ACCESS_WORD,
        op:            MEM_OP_READ,
        load_unsigned: 1'b0
    };

    function automatic logic is_store(input mem_params_t p);
        return p.op == MEM_OP_WRITE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and shared-memory signal bundle for mem_arbiter.
interface mem_arbiter_if;
    import mem_inc::*;

    // Fetch requester
    logic        if_req_valid;
    arch_reg_t   if_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    arch_reg_t   if_rsp_data;

    // Data requester
    logic        d_req_valid;
    arch_reg_t   d_addr;
    arch_reg_t   d_wdata;
    mem_params_t d_params;
    logic        d_req_ready;
    logic        d_rsp_valid;
    arch_reg_t   d_rsp_data;

    // Shared memory
    arch_reg_t   mem_address;
    arch_reg_t   mem_data_in;
    mem_params_t mem_params;
    arch_reg_t   mem_data_out;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_addr, d_wdata, d_params,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_address, mem_data_in, mem_params,
        input  mem_data_out
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_addr, d_wdata, d_params,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_address, mem_data_in, mem_params,
        output mem_data_out
    );

endinterface

// File: rtl/mem_arb_priority.sv
// Owner select: data wins a tie unless fetch has waited STARVE_LIMIT data grants.
module mem_arb_priority
    import mem_inc::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             if_valid,
    input  logic             d_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_owner_t       owner
);

    always_comb begin
        owner = OWNER_DATA;
        if (if_valid && (!d_valid || starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            owner = OWNER_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single shared memory,
// one transaction outstanding, fixed MEM_LATENCY read/write timing.
module mem_arbiter
    import mem_inc::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    arb_req_t         req_q, req_d;
    arch_reg_t        if_rsp_q, if_rsp_d;
    arch_reg_t        d_rsp_q, d_rsp_d;

    arb_owner_t       owner_sel;
    logic             grant_f;
    logic             grant_d;
    logic             any_valid;
    arch_reg_t        rdata;

    assign any_valid = bus.if_req_valid | bus.d_req_valid;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .if_valid   (bus.if_req_valid),
        .d_valid    (bus.d_req_valid),
        .starve_cnt (starve_q),
        .owner      (owner_sel)
    );

    // Stores complete with a zero response word
    assign rdata = is_store(req_q.params) ? '0 : bus.mem_data_out;

    // Next-state, grant and response-capture logic
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        req_d    = req_q;
        if_rsp_d = if_rsp_q;
        d_rsp_d  = d_rsp_q;
        grant_f  = 1'b0;
        grant_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    lat_d   = CNT_W'(MEM_LATENCY - 1);
                    if (owner_sel == OWNER_FETCH) begin
                        grant_f  = 1'b1;
                        starve_d = '0;
                        req_d    = '{addr:   bus.if_addr,
                                     wdata:  '0,
                                     params: FETCH_PARAMS,
                                     owner:  OWNER_FETCH};
                    end else begin
                        grant_d = 1'b1;
                        req_d   = '{addr:   bus.d_addr,
                                    wdata:  bus.d_wdata,
                                    params: bus.d_params,
                                    owner:  OWNER_DATA};
                        if (bus.if_req_valid && starve_q != CNT_W'(STARVE_LIMIT)) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end

            BUSY: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                    if (req_q.owner == OWNER_FETCH) begin
                        if_rsp_d = rdata;
                    end else begin
                        d_rsp_d = rdata;
                    end
                end else begin
                    lat_d = lat_q - CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            starve_q <= '0;
            req_q    <= '0;
            if_rsp_q <= '0;
            d_rsp_q  <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            req_q    <= req_d;
            if_rsp_q <= if_rsp_d;
            d_rsp_q  <= d_rsp_d;
        end
    end

    // Ready follows valid in IDLE; at most one of them is granted
    assign bus.if_req_ready = grant_f;
    assign bus.d_req_ready  = grant_d;

    // Memory sees the registered request only while BUSY, otherwise a harmless read of 0
    assign bus.mem_address = (state_q == BUSY) ? req_q.addr   : '0;
    assign bus.mem_data_in = (state_q == BUSY) ? req_q.wdata  : '0;
    assign bus.mem_params  = (state_q == BUSY) ? req_q.params : IDLE_PARAMS;

    assign bus.if_rsp_valid = (state_q == RESP) && (req_q.owner == OWNER_FETCH);
    assign bus.d_rsp_valid  = (state_q == RESP) && (req_q.owner == OWNER_DATA);
    assign bus.if_rsp_data  = if_rsp_q;
    assign bus.d_rsp_data   = d_rsp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (MEM_LATENCY 1 and 3) each with a word memory model.
module tb_mem_arbiter;
    import mem_inc::*;

    logic clock;
    logic reset;
    logic mem_clr;
    int   checks;
    int   errors;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem2 [0:255];

    mem_arbiter_if b1 ();
    mem_arbiter_if b2 ();

    mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memories: preset to 0xA500_0000 | index, synchronous write, asynchronous read
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'hA500_0000 | 32'(i);
        end else if (b1.mem_params.op == MEM_OP_WRITE) begin
            mem1[b1.mem_address[9:2]] <= b1.mem_data_in;
        end
    end
    assign b1.mem_data_out = mem1[b1.mem_address[9:2]];

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem2[i] <= 32'hA500_0000 | 32'(i);
        end else if (b2.mem_params.op == MEM_OP_WRITE) begin
            mem2[b2.mem_address[9:2]] <= b2.mem_data_in;
        end
    end
    assign b2.mem_data_out = mem2[b2.mem_address[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_grant [10];
        mem_params_t rd_params;
        mem_params_t wr_params;
        int w;

        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        rd_params = '{access_size: MEM_ACCESS_WORD, op: MEM_OP_READ,  load_unsigned: 1'b0};
        wr_params = '{access_size: MEM_ACCESS_WORD, op: MEM_OP_WRITE, load_unsigned: 1'b0};

        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        mem_clr = 1'b1;
        b1.if_req_valid = 1'b0; b1.if_addr = '0;
        b1.d_req_valid  = 1'b0; b1.d_addr = '0; b1.d_wdata = '0; b1.d_params = rd_params;
        b2.if_req_valid = 1'b0; b2.if_addr = '0;
        b2.d_req_valid  = 1'b0; b2.d_addr = '0; b2.d_wdata = '0; b2.d_params = rd_params;

        // Reset state
        step(); step();
        check("rst_state",       32'(dut1.state_q), 32'(IDLE));
        check("rst_if_rsp",      {31'd0, b1.if_rsp_valid}, 32'd0);
        check("rst_d_rsp",       {31'd0, b1.d_rsp_valid}, 32'd0);
        check("rst_if_data",     b1.if_rsp_data, 32'd0);
        check("rst_d_data",      b1.d_rsp_data, 32'd0);
        check("rst_mem_addr",    b1.mem_address, 32'd0);
        check("rst_mem_op",      32'(b1.mem_params.op), 32'(MEM_OP_READ));
        check("rst_ready",       {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'd0);
        mem_clr = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();

        // Lone fetch of 0x10 at latency 1
        b1.if_req_valid = 1'b1; b1.if_addr = 32'h10;
        #1;
        check("f_ready",         {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'b10);
        step();
        b1.if_req_valid = 1'b0;
        check("f_mem_addr",      b1.mem_address, 32'h10);
        check("f_mem_params",    32'(b1.mem_params), 32'(FETCH_PARAMS));
        check("f_busy_rsp",      {31'd0, b1.if_rsp_valid}, 32'd0);
        check("f_busy_ready",    {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'd0);
        step();
        check("f_rsp_valid",     {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'b10);
        check("f_rsp_data",      b1.if_rsp_data, 32'hA500_0004);
        step();
        check("f_rsp_pulse",     {31'd0, b1.if_rsp_valid}, 32'd0);
        check("f_rsp_hold",      b1.if_rsp_data, 32'hA500_0004);

        // Data load of 0x20
        b1.d_req_valid = 1'b1; b1.d_addr = 32'h20; b1.d_params = rd_params;
        #1;
        check("ld_ready",        {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'b01);
        step();
        b1.d_req_valid = 1'b0;
        step();
        check("ld_rsp_valid",    {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'b01);
        check("ld_rsp_data",     b1.d_rsp_data, 32'hA500_0008);
        step();

        // Store 0xDEADBEEF to 0x100, then fetch it back
        b1.d_req_valid = 1'b1; b1.d_addr = 32'h100; b1.d_wdata = 32'hDEAD_BEEF; b1.d_params = wr_params;
        #1;
        check("st_ready",        {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'b01);
        step();
        b1.d_req_valid = 1'b0;
        check("st_mem_op",       32'(b1.mem_params.op), 32'(MEM_OP_WRITE));
        check("st_mem_addr",     b1.mem_address, 32'h100);
        check("st_mem_wdata",    b1.mem_data_in, 32'hDEAD_BEEF);
        step();
        check("st_rsp_valid",    {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'b01);
        check("st_rsp_data",     b1.d_rsp_data, 32'd0);
        check("st_if_data_hold", b1.if_rsp_data, 32'hA500_0004);
        b1.if_req_valid = 1'b1; b1.if_addr = 32'h100;
        #1;
        check("resp_no_ready",   {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'd0);
        step();
        check("fb_ready",        {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'b10);
        step();
        b1.if_req_valid = 1'b0;
        check("fb_mem_op",       32'(b1.mem_params.op), 32'(MEM_OP_READ));
        step();
        check("fb_rsp_valid",    {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'b10);
        check("fb_rsp_data",     b1.if_rsp_data, 32'hDEAD_BEEF);
        step();

        // Both requesters continuously valid: D,D,D,D,F,D,D,D,D,F
        b1.if_req_valid = 1'b1; b1.if_addr = 32'h10;
        b1.d_req_valid  = 1'b1; b1.d_addr  = 32'h20; b1.d_params = rd_params;
        #1;
        for (int g = 0; g < 10; g++) begin
            w = 0;
            while (!(b1.if_req_ready || b1.d_req_ready) && w < 6) begin
                step();
                w++;
            end
            check("starve_grant", {30'd0, b1.if_req_ready, b1.d_req_ready}, {30'd0, exp_grant[g]});
            step();
        end
        b1.if_req_valid = 1'b0;
        b1.d_req_valid  = 1'b0;
        step(); step();

        // Latency 3 load: response exactly 4 cycles after handshake, no ready in between
        b2.d_req_valid = 1'b1; b2.d_addr = 32'h20; b2.d_params = rd_params;
        #1;
        check("l3_ready",        {30'd0, b2.if_req_ready, b2.d_req_ready}, 32'b01);
        b2.if_req_valid = 1'b1; b2.if_addr = 32'h10;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("l3_busy_ready", {30'd0, b2.if_req_ready, b2.d_req_ready}, 32'd0);
            check("l3_busy_rsp",   {30'd0, b2.if_rsp_valid, b2.d_rsp_valid}, 32'd0);
        end
        check("l3_mem_addr",     b2.mem_address, 32'h20);
        step();
        check("l3_rsp_valid",    {30'd0, b2.if_rsp_valid, b2.d_rsp_valid}, 32'b01);
        check("l3_rsp_data",     b2.d_rsp_data, 32'hA500_0008);
        check("l3_resp_ready",   {30'd0, b2.if_req_ready, b2.d_req_ready}, 32'd0);
        b2.if_req_valid = 1'b0;
        b2.d_req_valid  = 1'b0;
        step();

        // Reset during BUSY abandons the fetch
        b1.if_req_valid = 1'b1; b1.if_addr = 32'h30;
        #1;
        check("rb_ready",        {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'b10);
        step();
        b1.if_req_valid = 1'b0;
        check("rb_busy",         32'(dut1.state_q), 32'(BUSY));
        reset = 1'b0;
        #1;
        check("rb_state",        32'(dut1.state_q), 32'(IDLE));
        check("rb_no_rsp0",      {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'd0);
        step();
        check("rb_no_rsp1",      {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'd0);
        reset = 1'b1;
        step();
        check("rb_no_rsp2",      {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'd0);
        check("rb_data_clr",     b1.if_rsp_data, 32'd0);
        b1.if_req_valid = 1'b1; b1.if_addr = 32'h30;
        #1;
        check("ra_ready",        {30'd0, b1.if_req_ready, b1.d_req_ready}, 32'b10);
        step();
        b1.if_req_valid = 1'b0;
        step();
        check("ra_rsp_valid",    {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'b10);
        check("ra_rsp_data",     b1.if_rsp_data, 32'hA500_000C);
        step();

        // Quiet bus for 10 cycles
        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_quiet", {29'd0, b1.mem_params.op, b1.if_rsp_valid, b1.d_rsp_valid},
                  {29'd0, MEM_OP_READ, 1'b0, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, cycles from grant to response (legal 1..15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while a fetch waits (legal 1..15).
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port if_req_valid, input, 1, fetch requester has a read pending.
REQ-006 SHALL have port if_addr, input, 32 (arch_reg), fetch address.
REQ-007 SHALL have port if_req_ready, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port if_rsp_valid, output, 1, one-cycle pulse marking fetch data valid.
REQ-009 SHALL have port if_rsp_data, output, 32 (arch_reg), fetched word.
REQ-010 SHALL have port d_req_valid, input, 1, data requester has a load/store pending.
REQ-011 SHALL have ports d_addr (input, 32), d_wdata (input, 32) and d_params (input, mem_params_t), the data address, the store data and the access descriptor.
REQ-012 SHALL have ports d_req_ready (output, 1), d_rsp_valid (output, 1) and d_rsp_data (output, 32), with the same meanings as the fetch equivalents.
REQ-013 SHALL have ports mem_address (output, 32), mem_data_in (output, 32) and mem_params (output, mem_params_t), driving the single shared mem instance.
REQ-014 SHALL have port mem_data_out, input, 32, read data from the shared mem.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP, with at most one transaction outstanding.
REQ-016 SHALL assert if_req_ready or d_req_ready only in IDLE, never both in the same cycle; a handshake occurs when valid and ready are both high.
REQ-017 In IDLE, the arbitration rules are:
- If only one requester is valid, SHALL grant that requester.
- If both are valid, SHALL grant data, unless starve_cnt equals STARVE_LIMIT, in which case SHALL grant fetch.
REQ-018 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on every data grant made while if_req_valid is high.
REQ-019 SHALL clear starve_cnt on every fetch grant.
REQ-020 On a grant, SHALL register address, wdata, params and owner, and enter BUSY with lat_cnt = MEM_LATENCY-1.
- Fetch params are fixed: access_size MEM_ACCESS_WORD, op MEM_OP_READ, load_unsigned 1.
REQ-021 In BUSY, SHALL drive mem_* from the registered request, and decrement lat_cnt each cycle.
REQ-022 In BUSY, when lat_cnt is 0, SHALL capture mem_data_out into the response register and go to RESP.
REQ-023 In RESP, SHALL pulse the owner's rsp_valid for exactly one cycle, hold the captured data, and return to IDLE.
- Total latency from handshake to rsp_valid is MEM_LATENCY+1 cycles.
REQ-024 For a store, SHALL still pulse d_rsp_valid in RESP with d_rsp_data = 0.
REQ-025 Outside BUSY, SHALL drive mem_params.op = MEM_OP_READ, mem_address = 0 and mem_data_in = 0, so the memory performs no write.
REQ-026 Requesters SHALL hold valid and request fields stable until ready; the arbiter SHALL sample them only at handshake.
REQ-027 Back-to-back operation: a new grant SHALL be possible in the IDLE cycle immediately after RESP; sustained throughput is one transaction per MEM_LATENCY+2 cycles.
REQ-028 The rsp_data outputs SHALL hold their last value until the next RESP of the same owner.

Reset
REQ-029 While reset is low (asynchronous):
- state SHALL be IDLE;
- lat_cnt and starve_cnt SHALL be 0;
- the response registers SHALL be 0;
- all rsp_valid outputs SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction, with no rsp_valid pulse for it; a store already presented to mem is not undone.
REQ-031 The ready outputs SHALL follow their requesters' valid inputs from the first clock after reset deassertion.

Structure
REQ-032 The arb_state_t enum and arb_owner_t (OWNER_FETCH, OWNER_DATA) SHALL live in the shared mem_inc package alongside mem_params_t.
REQ-033 The owner-select logic SHALL be a sub-module mem_arb_priority (inputs: both valids, starve_cnt; output: grant owner), purely combinational.

Verification
REQ-034 Fetch alone, MEM_LATENCY=1: if_addr=0x10 is accepted at cycle 0; mem_address=0x10 in cycle 1; if_rsp_valid in cycle 2 with if_rsp_data equal to the word at 0x10.
REQ-035 Both valid continuously, STARVE_LIMIT=4: grant order SHALL be D,D,D,D,F,D,D,D,D,F.
REQ-036 Store d_addr=0x100, d_wdata=0xDEADBEEF, then fetch 0x100: d_rsp_valid with data 0 SHALL occur first; the fetch SHALL then return 0xDEADBEEF.
REQ-037 MEM_LATENCY=3, load granted: d_rsp_valid SHALL rise exactly 4 cycles after the handshake; no ready SHALL be asserted in between.
REQ-038 Reset pulled low during BUSY: no rsp_valid SHALL appear, state SHALL be IDLE, and a fetch issued after reset SHALL complete normally.
REQ-039 Idle with no requests for 10 cycles: mem_params.op SHALL stay MEM_OP_READ and both rsp_valid outputs SHALL stay 0.
